// File: rtl/serial_subtractor_if.sv
// serial_subtractor_if
//   Groups the controller-facing signals of the bit-serial subtractor.
//   master: controller side (drives start/a/b/bin, observes the result).
//   slave : subtractor side (samples the request, drives status/result).
//   start  request, honoured only while the subtractor is idle
//   a, b   minuend / subtrahend (WIDTH bits)
//   bin    borrow-in
//   busy   high while bits are being processed
//   done   one-cycle pulse when diff/bout/zero hold a fresh result
//   diff   registered result (a - b - bin) mod 2^WIDTH
//   bout   final borrow-out (unsigned underflow)
//   zero   diff == 0, updated together with diff
interface serial_subtractor_if #(
  parameter int WIDTH = 3
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             zero;

  modport master (
    output start, a, b, bin,
    input  busy, done, diff, bout, zero
  );

  modport slave (
    input  start, a, b, bin,
    output busy, done, diff, bout, zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// serial_subtractor
//   Bit-serial two's-complement subtractor. Computes a - b - bin one bit per
//   clock, LSB first, with one full-subtractor cell and a borrow flop.
//   Ports:
//     clk  rising-edge clock
//     rst  synchronous active-high reset
//     bus  serial_subtractor_if.slave (start/a/b/bin in, busy/done/diff/bout/zero out)
//   Timing: start accepted at edge k -> busy for WIDTH cycles -> done pulse
//   for one cycle -> idle. Requests during busy/done are ignored.
module serial_subtractor #(
  parameter int WIDTH = 3
) (
  input  logic                clk,
  input  logic                rst,
  serial_subtractor_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg;
  state_t           state_next;

  logic [WIDTH-1:0] sa_reg;
  logic [WIDTH-1:0] sb_reg;
  logic [WIDTH-1:0] sd_reg;
  logic [WIDTH-1:0] sd_shift;
  logic             br_reg;
  logic [CW-1:0]    cnt_reg;

  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             zero_reg;

  logic             x;
  logic             y;
  logic             d;
  logic             br_next;
  logic             last_bit;

  // Full-subtractor cell on the current LSBs.
  assign x        = sa_reg[0];
  assign y        = sb_reg[0];
  assign d        = x ^ y ^ br_reg;
  assign br_next  = (~x & y) | (~x & br_reg) | (y & br_reg);
  assign last_bit = (cnt_reg == LAST_BIT);

  // Result register shifted right with the new difference bit entering at
  // the MSB; after WIDTH shifts bit 0 of the result sits in sd[0].
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_sd_shift
      if (gi == WIDTH - 1) begin : g_msb
        assign sd_shift[gi] = d;
      end else begin : g_low
        assign sd_shift[gi] = sd_reg[gi+1];
      end
    end
  endgenerate

  // Next-state logic.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (last_bit)  state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Datapath: operand capture, serial processing and result update.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_reg   <= '0;
      sb_reg   <= '0;
      sd_reg   <= '0;
      br_reg   <= 1'b0;
      cnt_reg  <= '0;
      diff_reg <= '0;
      bout_reg <= 1'b0;
      zero_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            sa_reg  <= bus.a;
            sb_reg  <= bus.b;
            br_reg  <= bus.bin;
            cnt_reg <= '0;
          end
        end
        RUN: begin
          sa_reg  <= sa_reg >> 1;
          sb_reg  <= sb_reg >> 1;
          sd_reg  <= sd_shift;
          br_reg  <= br_next;
          cnt_reg <= cnt_reg + 1'b1;
          // Published results only change on the final bit so the previous
          // result stays visible for the whole run.
          if (last_bit) begin
            diff_reg <= sd_shift;
            bout_reg <= br_next;
            zero_reg <= (sd_shift == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = (state_reg == RUN);
  assign bus.done = (state_reg == DONE);
  assign bus.diff = diff_reg;
  assign bus.bout = bout_reg;
  assign bus.zero = zero_reg;

endmodule

// File: tb/tb_serial_subtractor.sv
// tb_serial_subtractor
//   Two instances (WIDTH=3 and WIDTH=8). Stimulus pushes expected results
//   from an arithmetic reference model into per-instance queues; monitors
//   pop and compare on every done pulse.
module tb_serial_subtractor;

  logic clk;
  logic rst;

  typedef struct {
    int diff;
    int bout;
    int zero;
  } exp_t;

  exp_t q3[$];
  exp_t q8[$];

  int total;
  int bad;

  serial_subtractor_if #(.WIDTH(3)) if3 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  serial_subtractor #(.WIDTH(3)) u3 (.clk(clk), .rst(rst), .bus(if3.slave));
  serial_subtractor #(.WIDTH(8)) u8 (.clk(clk), .rst(rst), .bus(if8.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // Reference model: plain integer arithmetic.
  function automatic exp_t model(input int w, input int av, input int bv, input int bi);
    exp_t e;
    int m;
    m      = 1 << w;
    e.diff = (((av - bv - bi) % m) + m) % m;
    e.bout = (av < bv + bi) ? 1 : 0;
    e.zero = (e.diff == 0) ? 1 : 0;
    return e;
  endfunction

  task automatic set_inputs(input int w, input logic st, input int av, input int bv, input int bi);
    if (w == 3) begin
      if3.start = st;
      if3.a     = 3'(av);
      if3.b     = 3'(bv);
      if3.bin   = 1'(bi);
    end else begin
      if8.start = st;
      if8.a     = 8'(av);
      if8.b     = 8'(bv);
      if8.bin   = 1'(bi);
    end
  endtask

  function automatic logic get_busy(input int w);
    return (w == 3) ? if3.busy : if8.busy;
  endfunction

  function automatic logic get_done(input int w);
    return (w == 3) ? if3.done : if8.done;
  endfunction

  task automatic push(input int w, input exp_t e);
    if (w == 3) q3.push_back(e);
    else        q8.push_back(e);
  endtask

  // One operation with a timing check: busy for w cycles, then done at w+1.
  task automatic run_op(input int w, input int av, input int bv, input int bi);
    int busy_n;
    int done_at;
    @(negedge clk);
    set_inputs(w, 1'b1, av, bv, bi);
    push(w, model(w, av, bv, bi));
    @(posedge clk);
    #1;
    // Scramble operands after acceptance; only captured values may matter.
    set_inputs(w, 1'b0, int'($urandom), int'($urandom), int'($urandom_range(0, 1)));
    busy_n  = 0;
    done_at = 0;
    for (int i = 1; i <= w + 3; i++) begin
      @(negedge clk);
      if (get_busy(w)) busy_n++;
      if (get_done(w) && done_at == 0) done_at = i;
    end
    check($sformatf("busy_cycles w%0d a=%0d b=%0d", w, av, bv), busy_n, w);
    check($sformatf("done_latency w%0d a=%0d b=%0d", w, av, bv), done_at, w + 1);
  endtask

  // Scoreboard monitors.
  always @(negedge clk) begin
    if (if3.done) begin
      if (q3.size() == 0) begin
        check("w3 unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q3.pop_front();
        check("w3 diff", int'(if3.diff), e.diff);
        check("w3 bout", int'(if3.bout), e.bout);
        check("w3 zero", int'(if3.zero), e.zero);
        $display("w3 result diff=%0d bout=%0d zero=%0d", if3.diff, if3.bout, if3.zero);
      end
    end
  end

  always @(negedge clk) begin
    if (if8.done) begin
      if (q8.size() == 0) begin
        check("w8 unexpected_done", 1, 0);
      end else begin
        exp_t e;
        e = q8.pop_front();
        check("w8 diff", int'(if8.diff), e.diff);
        check("w8 bout", int'(if8.bout), e.bout);
        check("w8 zero", int'(if8.zero), e.zero);
        $display("w8 result diff=%0d bout=%0d zero=%0d", if8.diff, if8.bout, if8.zero);
      end
    end
  end

  task automatic check_cleared(input string tag);
    check({tag, " w3 busy"}, int'(if3.busy), 0);
    check({tag, " w3 done"}, int'(if3.done), 0);
    check({tag, " w3 diff"}, int'(if3.diff), 0);
    check({tag, " w3 bout"}, int'(if3.bout), 0);
    check({tag, " w3 zero"}, int'(if3.zero), 0);
  endtask

  initial begin
    exp_t e;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    set_inputs(3, 1'b0, 0, 0, 0);
    set_inputs(8, 1'b0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_cleared("reset");
    check("reset w8 busy", int'(if8.busy), 0);
    check("reset w8 diff", int'(if8.diff), 0);
    rst = 1'b0;

    // Directed WIDTH=3 cases.
    run_op(3, 5, 3, 0);
    run_op(3, 3, 5, 0);
    run_op(3, 4, 4, 0);
    run_op(3, 0, 0, 1);

    // Exhaustive sweep, 128 combinations.
    for (int av = 0; av < 8; av++)
      for (int bv = 0; bv < 8; bv++)
        for (int bi = 0; bi < 2; bi++)
          run_op(3, av, bv, bi);

    // start held high; operands changing during RUN/DONE.
    @(negedge clk);
    set_inputs(3, 1'b1, 1, 0, 0);
    push(3, model(3, 1, 0, 0));
    @(posedge clk);
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      set_inputs(3, 1'b1, int'($urandom), int'($urandom), int'($urandom_range(0, 1)));
    end
    @(negedge clk);
    set_inputs(3, 1'b1, 6, 2, 1);
    push(3, model(3, 6, 2, 1));
    @(posedge clk);
    #1;
    set_inputs(3, 1'b0, 0, 0, 0);
    repeat (8) @(negedge clk);

    // Leave a non-zero result, then abort an op on its 2nd RUN cycle.
    run_op(3, 3, 5, 0);
    @(negedge clk);
    set_inputs(3, 1'b1, 7, 1, 0);
    @(posedge clk);
    #1;
    set_inputs(3, 1'b0, 0, 0, 0);
    @(negedge clk);
    check("abort run1 busy", int'(if3.busy), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("abort");
    rst = 1'b0;
    repeat (10) @(negedge clk);

    // rst and start together: not accepted.
    set_inputs(3, 1'b1, 2, 1, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_inputs(3, 1'b0, 0, 0, 0);
    check("rst_vs_start busy", int'(if3.busy), 0);
    repeat (6) @(negedge clk);

    // WIDTH=8 directed and random.
    run_op(8, 200, 55, 0);
    run_op(8, 55, 200, 0);
    run_op(8, 128, 128, 0);
    run_op(8, 0, 255, 1);
    for (int n = 0; n < 24; n++)
      run_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), int'($urandom_range(0, 1)));

    repeat (12) @(negedge clk);
    check("w3 pending_results", q3.size(), 0);
    check("w8 pending_results", q8.size(), 0);
    e = model(3, 5, 3, 0);
    check("model sanity w3 5-3", e.diff, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
